// File: rtl/int_ctrl_pkg.sv
// Shared CP0 definitions for the exception/interrupt controller:
// register numbers, exception codes and controller state encoding.
package int_ctrl_pkg;

  localparam logic [4:0] CP0_STATUS = 5'd12;
  localparam logic [4:0] CP0_CAUSE  = 5'd13;
  localparam logic [4:0] CP0_EPC    = 5'd14;

  localparam logic [4:0] EXC_INT = 5'd0;
  localparam logic [4:0] EXC_SYS = 5'd8;

  typedef enum logic {
    RUN   = 1'b0,
    REDIR = 1'b1
  } state_t;

endpackage

// File: rtl/int_ctrl_irq_prio_enc.sv
// Fixed-priority encoder: the highest-index asserted request wins.
// Returns a one-hot grant and a flag telling whether any request was set.
module irq_prio_enc #(
  parameter int N = 3
) (
  input  logic [N-1:0] req,
  output logic         valid,
  output logic [N-1:0] grant
);

  // above[k] is set when any request at index >= k is asserted
  logic [N:0] above;

  assign above[N] = 1'b0;

  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_chain
      assign above[gi] = above[gi+1] | req[gi];
      assign grant[gi] = req[gi] & ~above[gi+1];
    end
  endgenerate

  assign valid = above[0];

endmodule

// File: rtl/int_ctrl.sv
// Coprocessor-0 style exception/interrupt controller: owns Status, Cause
// and EPC, and issues one-cycle PC redirects to the trap vector or to EPC.
module int_ctrl
  import int_ctrl_pkg::*;
#(
  parameter int          NIRQ         = 3,
  parameter logic [31:0] HANDLER_ADDR = 32'h0000_0800
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NIRQ-1:0] irq,
  input  logic            inst_valid,
  input  logic [31:0]     pc,
  input  logic            syscall,
  input  logic            eret,
  input  logic            mtc0,
  input  logic            mfc0,
  input  logic [4:0]      cp0_sel,
  input  logic [31:0]     wdata,
  output logic [31:0]     rdata,
  output logic            redirect,
  output logic [31:0]     redirect_pc,
  output logic            flush,
  output logic            int_en
);

  state_t          state_reg, state_next;
  logic            ie_reg, ie_next;
  logic [NIRQ-1:0] mask_reg, mask_next;
  logic [NIRQ-1:0] pending_reg, pending_next, pending_clr;
  logic [NIRQ-1:0] irq_q_reg;
  logic [4:0]      exc_reg, exc_next;
  logic [31:0]     epc_reg, epc_next;
  logic [31:0]     redirect_pc_reg, redirect_pc_next;

  logic            int_gate;
  logic            int_take;
  logic [NIRQ-1:0] int_grant;

  // mfc0 has no side effects; reads are purely combinational from cp0_sel
  logic unused_mfc0;
  assign unused_mfc0 = mfc0;

  assign int_gate = ie_reg & inst_valid & (state_reg == RUN) & ~syscall & ~eret;

  irq_prio_enc #(.N(NIRQ)) u_prio (
    .req   (pending_reg & mask_reg & {NIRQ{int_gate}}),
    .valid (int_take),
    .grant (int_grant)
  );

  always_comb begin
    state_next       = state_reg;
    ie_next          = ie_reg;
    mask_next        = mask_reg;
    pending_clr      = '0;
    exc_next         = exc_reg;
    epc_next         = epc_reg;
    redirect_pc_next = redirect_pc_reg;

    if (state_reg == REDIR) begin
      state_next = RUN;
    end else if (inst_valid) begin
      if (syscall || int_take) begin
        state_next       = REDIR;
        epc_next         = pc + 32'd4;
        exc_next         = syscall ? EXC_SYS : EXC_INT;
        ie_next          = 1'b0;
        redirect_pc_next = HANDLER_ADDR;
        pending_clr      = int_grant;
      end else if (eret) begin
        state_next       = REDIR;
        ie_next          = 1'b1;
        redirect_pc_next = epc_reg;
      end else if (mtc0) begin
        case (cp0_sel)
          CP0_STATUS: begin
            ie_next   = wdata[0];
            mask_next = wdata[8 +: NIRQ];
          end
          CP0_CAUSE: pending_clr = wdata[8 +: NIRQ];
          CP0_EPC:   epc_next    = wdata;
          default:   ;
        endcase
      end
    end

    // a new edge in the same cycle beats any clear
    pending_next = (pending_reg & ~pending_clr) | (irq & ~irq_q_reg);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg       <= RUN;
      ie_reg          <= 1'b0;
      mask_reg        <= '0;
      pending_reg     <= '0;
      irq_q_reg       <= '0;
      exc_reg         <= EXC_INT;
      epc_reg         <= '0;
      redirect_pc_reg <= '0;
    end else begin
      state_reg       <= state_next;
      ie_reg          <= ie_next;
      mask_reg        <= mask_next;
      pending_reg     <= pending_next;
      irq_q_reg       <= irq;
      exc_reg         <= exc_next;
      epc_reg         <= epc_next;
      redirect_pc_reg <= redirect_pc_next;
    end
  end

  always_comb begin
    rdata = '0;
    case (cp0_sel)
      CP0_STATUS: begin
        rdata[0]         = ie_reg;
        rdata[8 +: NIRQ] = mask_reg;
      end
      CP0_CAUSE: begin
        rdata[8 +: NIRQ] = pending_reg;
        rdata[6:2]       = exc_reg;
      end
      CP0_EPC: rdata = epc_reg;
      default: ;
    endcase
  end

  assign redirect    = (state_reg == REDIR);
  assign flush       = redirect;
  assign redirect_pc = redirect_pc_reg;
  assign int_en      = ie_reg;

endmodule

// File: tb/tb_int_ctrl.sv
// Self-checking bench for int_ctrl: expected redirect targets are queued
// when a trapping instruction is driven and popped when redirect appears.
module tb_int_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [2:0]  irq = '0;
  logic        inst_valid = 1'b0;
  logic [31:0] pc = '0;
  logic        syscall = 1'b0, eret = 1'b0, mtc0 = 1'b0, mfc0 = 1'b0;
  logic [4:0]  cp0_sel = '0;
  logic [31:0] wdata = '0;
  logic [31:0] rdata, redirect_pc;
  logic        redirect, flush, int_en;

  int checks = 0;
  int failures = 0;
  logic [31:0] exp_q[$];
  logic [31:0] exp_pc, d;

  int_ctrl #(.NIRQ(3), .HANDLER_ADDR(32'h0000_0800)) dut (
    .clk(clk), .rst(rst), .irq(irq), .inst_valid(inst_valid), .pc(pc),
    .syscall(syscall), .eret(eret), .mtc0(mtc0), .mfc0(mfc0),
    .cp0_sel(cp0_sel), .wdata(wdata), .rdata(rdata), .redirect(redirect),
    .redirect_pc(redirect_pc), .flush(flush), .int_en(int_en)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    inst_valid = 0; syscall = 0; eret = 0; mtc0 = 0; mfc0 = 0; wdata = '0;
  endtask

  task automatic drive(input logic [31:0] p, input logic s, input logic e,
                       input logic mt, input logic [4:0] sel, input logic [31:0] wd);
    inst_valid = 1; pc = p; syscall = s; eret = e; mtc0 = mt; mfc0 = 0;
    cp0_sel = sel; wdata = wd;
  endtask

  task automatic rd(input logic [4:0] sel, output logic [31:0] v);
    inst_valid = 0; mfc0 = 1; cp0_sel = sel;
    #1;
    v = rdata;
    mfc0 = 0;
  endtask

  task automatic test_reset();
    rst = 1; idle();
    repeat (2) @(posedge clk);
    #1 rst = 0;
    for (int s = 12; s <= 14; s++) begin
      rd(5'(s), d);
      checks++;
      if (d !== 32'h0) begin
        failures++;
        $display("FAIL reset_sel%0d: got %h expected 00000000", s, d);
      end
    end
    checks++;
    if (redirect !== 1'b0 || int_en !== 1'b0) begin
      failures++;
      $display("FAIL reset_out: redirect=%b int_en=%b expected 0 0", redirect, int_en);
    end
  endtask

  task automatic test_syscall();
    drive(32'h0000_1000, 1, 0, 0, 5'd0, '0);
    exp_q.push_back(32'h0000_0800);
    tick(); idle();
    checks++;
    if (redirect !== 1'b1 || flush !== 1'b1 || exp_q.size() == 0) begin
      failures++;
      $display("FAIL sys_redirect: redirect=%b flush=%b queued=%0d expected 1 1 >0", redirect, flush, exp_q.size());
    end else begin
      exp_pc = exp_q.pop_front();
      $display("redirect to %h (syscall)", redirect_pc);
      checks++;
      if (redirect_pc !== exp_pc) begin
        failures++;
        $display("FAIL sys_target: got %h expected %h", redirect_pc, exp_pc);
      end
    end
    rd(5'd14, d);
    checks++;
    if (d !== 32'h0000_1004) begin
      failures++; $display("FAIL sys_epc: got %h expected 00001004", d);
    end
    rd(5'd13, d);
    checks++;
    if (d[6:2] !== 5'd8 || int_en !== 1'b0) begin
      failures++; $display("FAIL sys_cause: exc=%0d ie=%b expected 8 0", d[6:2], int_en);
    end
    tick();
    checks++;
    if (redirect !== 1'b0) begin
      failures++; $display("FAIL sys_pulse: redirect=%b expected 0", redirect);
    end
  endtask

  task automatic test_irq_entry();
    drive(32'h0000_1100, 0, 0, 1, 5'd12, 32'h0000_0501);
    tick(); idle();
    checks++;
    if (redirect !== 1'b0 || int_en !== 1'b1) begin
      failures++; $display("FAIL status_wr: redirect=%b ie=%b expected 0 1", redirect, int_en);
    end
    irq = 3'b101;
    tick();
    irq = 3'b000;
    rd(5'd13, d);
    checks++;
    if (d[10:8] !== 3'b101) begin
      failures++; $display("FAIL irq_capture: pending=%b expected 101", d[10:8]);
    end
    drive(32'h0000_2000, 0, 0, 0, 5'd0, '0);
    exp_q.push_back(32'h0000_0800);
    tick(); idle();
    checks++;
    if (redirect !== 1'b1 || exp_q.size() == 0) begin
      failures++; $display("FAIL irq_redirect: redirect=%b queued=%0d expected 1 >0", redirect, exp_q.size());
    end else begin
      exp_pc = exp_q.pop_front();
      $display("redirect to %h (interrupt)", redirect_pc);
      checks++;
      if (redirect_pc !== exp_pc) begin
        failures++; $display("FAIL irq_target: got %h expected %h", redirect_pc, exp_pc);
      end
    end
    rd(5'd14, d);
    checks++;
    if (d !== 32'h0000_2004) begin
      failures++; $display("FAIL irq_epc: got %h expected 00002004", d);
    end
    rd(5'd13, d);
    checks++;
    if (d[10:8] !== 3'b001 || d[6:2] !== 5'd0) begin
      failures++; $display("FAIL irq_cause: pending=%b exc=%0d expected 001 0", d[10:8], d[6:2]);
    end
    tick();
  endtask

  task automatic test_eret_then_irq();
    drive(32'h0000_0800, 0, 1, 0, 5'd0, '0);
    exp_q.push_back(32'h0000_2004);
    tick(); idle();
    checks++;
    if (redirect !== 1'b1 || int_en !== 1'b1 || exp_q.size() == 0) begin
      failures++; $display("FAIL eret_redirect: redirect=%b ie=%b queued=%0d expected 1 1 >0", redirect, int_en, exp_q.size());
    end else begin
      exp_pc = exp_q.pop_front();
      $display("redirect to %h (eret)", redirect_pc);
      checks++;
      if (redirect_pc !== exp_pc) begin
        failures++; $display("FAIL eret_target: got %h expected %h", redirect_pc, exp_pc);
      end
    end
    tick();
    drive(32'h0000_2004, 0, 0, 0, 5'd0, '0);
    exp_q.push_back(32'h0000_0800);
    tick(); idle();
    checks++;
    if (redirect !== 1'b1 || exp_q.size() == 0) begin
      failures++; $display("FAIL irq0_redirect: redirect=%b queued=%0d expected 1 >0", redirect, exp_q.size());
    end else begin
      exp_pc = exp_q.pop_front();
      $display("redirect to %h (interrupt)", redirect_pc);
      checks++;
      if (redirect_pc !== exp_pc) begin
        failures++; $display("FAIL irq0_target: got %h expected %h", redirect_pc, exp_pc);
      end
    end
    rd(5'd14, d);
    checks++;
    if (d !== 32'h0000_2008) begin
      failures++; $display("FAIL irq0_epc: got %h expected 00002008", d);
    end
    tick();
  endtask

  task automatic test_sys_vs_irq();
    drive(32'h0000_0900, 0, 0, 1, 5'd12, 32'h0000_0501);
    tick(); idle();
    irq = 3'b001;
    tick();
    irq = 3'b000;
    drive(32'h0000_3000, 1, 0, 0, 5'd0, '0);
    exp_q.push_back(32'h0000_0800);
    tick(); idle();
    checks++;
    if (redirect !== 1'b1 || exp_q.size() == 0) begin
      failures++; $display("FAIL prio_redirect: redirect=%b queued=%0d expected 1 >0", redirect, exp_q.size());
    end else begin
      exp_pc = exp_q.pop_front();
      $display("redirect to %h (syscall over interrupt)", redirect_pc);
      checks++;
      if (redirect_pc !== exp_pc) begin
        failures++; $display("FAIL prio_target: got %h expected %h", redirect_pc, exp_pc);
      end
    end
    rd(5'd13, d);
    checks++;
    if (d !== 32'h0000_0120) begin
      failures++; $display("FAIL prio_cause: got %h expected 00000120", d);
    end
    tick();
    drive(32'h0000_0800, 0, 0, 1, 5'd13, 32'h0000_0100);
    tick(); idle();
    rd(5'd13, d);
    checks++;
    if (d !== 32'h0000_0020 || redirect !== 1'b0) begin
      failures++; $display("FAIL cause_w1c: got %h redirect=%b expected 00000020 0", d, redirect);
    end
    drive(32'h0000_0804, 0, 0, 1, 5'd5, 32'hFFFF_FFFF);
    tick(); idle();
    rd(5'd5, d);
    checks++;
    if (d !== 32'h0) begin
      failures++; $display("FAIL unmapped_sel: got %h expected 00000000", d);
    end
  endtask

  task automatic test_async_reset();
    drive(32'h0000_4000, 1, 0, 0, 5'd0, '0);
    exp_q.push_back(32'h0000_0800);
    tick(); idle();
    checks++;
    if (redirect !== 1'b1 || exp_q.size() == 0) begin
      failures++; $display("FAIL rst_pre: redirect=%b queued=%0d expected 1 >0", redirect, exp_q.size());
    end else begin
      exp_pc = exp_q.pop_front();
      $display("redirect to %h (syscall before reset)", redirect_pc);
    end
    #2 rst = 1;
    #1;
    checks++;
    if (redirect !== 1'b0 || flush !== 1'b0) begin
      failures++; $display("FAIL rst_async: redirect=%b flush=%b expected 0 0", redirect, flush);
    end
    for (int s = 12; s <= 14; s++) begin
      rd(5'(s), d);
      checks++;
      if (d !== 32'h0) begin
        failures++; $display("FAIL rst_sel%0d: got %h expected 00000000", s, d);
      end
    end
    @(posedge clk);
    #1 rst = 0;
    checks++;
    if (exp_q.size() != 0) begin
      failures++; $display("FAIL scoreboard_drain: %0d entries left expected 0", exp_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_syscall();
    test_irq_entry();
    test_eret_then_irq();
    test_sys_vs_irq();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
